// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle of the branch predictor.
// master = pipeline, slave = predictor.
interface branch_predictor_if;
   logic [31:0] if_pc;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_br;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] upd_pred_pc;
   logic        correct_pc_prediction;
   logic [31:0] correct_pc;
   logic [31:0] br_count;
   logic [31:0] mispredict_count;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_is_br, upd_is_jump,
      output upd_taken, upd_target, upd_pred_pc,
      input  pred_pc, pred_taken, correct_pc_prediction,
      input  correct_pc, br_count, mispredict_count
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_is_br, upd_is_jump,
      input  upd_taken, upd_target, upd_pred_pc,
      output pred_pc, pred_taken, correct_pc_prediction,
      output correct_pc, br_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters beside IF; resolves
// EX outcomes, trains the table and counts mispredicts.
module branch_predictor #(
   parameter int IDX_BITS = 4
) (
   input logic                clk,
   input logic                rst,
   branch_predictor_if.slave  bp
);
   localparam int TAG_BITS = 30 - IDX_BITS;
   localparam int ENTRIES  = 1 << IDX_BITS;

   typedef logic [IDX_BITS-1:0] idx_t;
   typedef logic [TAG_BITS-1:0] tag_t;

   logic        r_valid  [ENTRIES];
   logic        r_jump   [ENTRIES];
   tag_t        r_tag    [ENTRIES];
   logic [31:0] r_target [ENTRIES];
   logic [1:0]  r_cnt    [ENTRIES];
   logic [31:0] r_br_count;
   logic [31:0] r_mis_count;

   idx_t        w_if_idx;
   tag_t        w_if_tag;
   logic        w_if_hit;
   logic        w_pred_taken;
   logic [31:0] w_seq_pc;

   idx_t        w_u_idx;
   tag_t        w_u_tag;
   logic        w_u_hit;
   logic        w_u_jmp;
   logic        w_u_br;
   logic        w_u_cf;
   logic [31:0] w_actual;
   logic        w_cpp;

   logic        w_we;
   logic        w_n_valid;
   logic        w_n_jump;
   logic [31:0] w_n_target;
   logic [1:0]  w_n_cnt;
   logic [1:0]  w_u_cnt;
   logic        w_unused;

   // Word-aligned PCs: the two low bits never select anything.
   assign w_unused = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

   assign w_if_idx = bp.if_pc[IDX_BITS+1:2];
   assign w_if_tag = bp.if_pc[31:IDX_BITS+2];
   assign w_if_hit = r_valid[w_if_idx]
                  && (r_tag[w_if_idx] == w_if_tag);
   assign w_pred_taken = w_if_hit
                      && (r_jump[w_if_idx] || r_cnt[w_if_idx][1]);
   assign w_seq_pc = bp.if_pc + 32'd4;

   assign bp.pred_taken = w_pred_taken;
   assign bp.pred_pc    = w_pred_taken ? r_target[w_if_idx]
                                       : w_seq_pc;

   assign w_u_idx = bp.upd_pc[IDX_BITS+1:2];
   assign w_u_tag = bp.upd_pc[31:IDX_BITS+2];
   assign w_u_hit = r_valid[w_u_idx]
                 && (r_tag[w_u_idx] == w_u_tag);
   assign w_u_cnt = r_cnt[w_u_idx];

   // Both flags set is illegal and resolves as a jump.
   assign w_u_jmp = bp.upd_is_jump;
   assign w_u_br  = bp.upd_is_br && !bp.upd_is_jump;
   assign w_u_cf  = bp.upd_is_br || bp.upd_is_jump;

   always_comb begin
      w_actual = bp.upd_pc + 32'd4;
      if (w_u_jmp || (w_u_br && bp.upd_taken))
         w_actual = bp.upd_target;
   end

   assign w_cpp = !bp.upd_valid || (bp.upd_pred_pc == w_actual);

   assign bp.correct_pc            = w_actual;
   assign bp.correct_pc_prediction = w_cpp;
   assign bp.br_count              = r_br_count;
   assign bp.mispredict_count      = r_mis_count;

   always_comb begin
      w_we       = 1'b0;
      w_n_valid  = r_valid[w_u_idx];
      w_n_jump   = r_jump[w_u_idx];
      w_n_target = r_target[w_u_idx];
      w_n_cnt    = w_u_cnt;
      unique case (1'b1)
         w_u_jmp: begin
            w_we       = 1'b1;
            w_n_valid  = 1'b1;
            w_n_jump   = 1'b1;
            w_n_target = bp.upd_target;
            w_n_cnt    = 2'b11;
         end
         w_u_br: begin
            if (w_u_hit) begin
               w_we     = 1'b1;
               w_n_jump = 1'b0;
               if (bp.upd_taken) begin
                  w_n_target = bp.upd_target;
                  w_n_cnt    = (w_u_cnt == 2'b11) ? 2'b11
                                                  : w_u_cnt + 2'd1;
               end else begin
                  w_n_cnt = (w_u_cnt == 2'b00) ? 2'b00
                                               : w_u_cnt - 2'd1;
               end
            end else if (bp.upd_taken) begin
               w_we       = 1'b1;
               w_n_valid  = 1'b1;
               w_n_jump   = 1'b0;
               w_n_target = bp.upd_target;
               w_n_cnt    = 2'b10;
            end
         end
         default: begin
            // A non-control instruction hitting means a stale alias.
            if (w_u_hit) begin
               w_we      = 1'b1;
               w_n_valid = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[idx_t'(i)] <= 1'b0;
            r_jump[idx_t'(i)]  <= 1'b0;
            r_cnt[idx_t'(i)]   <= 2'b01;
         end
         r_br_count  <= '0;
         r_mis_count <= '0;
      end else if (bp.upd_valid) begin
         if (w_we) begin
            r_valid[w_u_idx]  <= w_n_valid;
            r_jump[w_u_idx]   <= w_n_jump;
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= w_n_target;
            r_cnt[w_u_idx]    <= w_n_cnt;
         end
         if (w_u_cf)
            r_br_count <= r_br_count + 32'd1;
         if (!w_cpp)
            r_mis_count <= r_mis_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, corner
// sequences, then random traffic against a behavioural model.
module tb_branch_predictor;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   branch_predictor_if bus ();

   branch_predictor dut (
      .clk (clk),
      .rst (rst),
      .bp  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        uv, br, jp, tk;
      logic [31:0] upc, utgt, upred, ipc;
      logic [31:0] e_pred;
      logic        e_ptk, e_cpp;
      logic [31:0] e_cpc;
   } vec_t;

   vec_t tbl[$];

   bit          m_v   [16];
   bit          m_j   [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_c   [16];
   logic [31:0] m_br;
   logic [31:0] m_mis;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic uv, input logic br,
                        input logic jp, input logic tk,
                        input logic [31:0] upc,
                        input logic [31:0] utgt,
                        input logic [31:0] upred,
                        input logic [31:0] ipc);
      bus.upd_valid   = uv;
      bus.upd_is_br   = br;
      bus.upd_is_jump = jp;
      bus.upd_taken   = tk;
      bus.upd_pc      = upc;
      bus.upd_target  = utgt;
      bus.upd_pred_pc = upred;
      bus.if_pc       = ipc;
   endtask

   task automatic idle(input logic [31:0] ipc,
                       input logic [31:0] ep, input logic et);
      vec_t v;
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ipc,
            ep, et, 1'b1, 32'h4};
      tbl.push_back(v);
   endtask

   task automatic upd(input logic br, input logic jp,
                      input logic tk, input logic [31:0] upc,
                      input logic [31:0] utgt,
                      input logic [31:0] upred,
                      input logic [31:0] ipc,
                      input logic [31:0] ep, input logic et,
                      input logic ec, input logic [31:0] ecpc);
      vec_t v;
      v = '{1'b1, br, jp, tk, upc, utgt, upred, ipc,
            ep, et, ec, ecpc};
      tbl.push_back(v);
   endtask

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int i;
      i = m_idx(pc);
      return m_v[i] && (m_tag[i] == (pc >> 6));
   endfunction

   task automatic m_predict(input logic [31:0] pc,
                            output logic [31:0] npc,
                            output logic tk);
      int i;
      i  = m_idx(pc);
      tk = m_hit(pc) && (m_j[i] || m_c[i] >= 2);
      npc = tk ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic m_clear();
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 0;
         m_j[i] = 0;
         m_c[i] = 1;
      end
      m_br  = 0;
      m_mis = 0;
   endtask

   task automatic m_train(input logic br, input logic jp,
                          input logic tk, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic ok);
      int i;
      bit h;
      i = m_idx(pc);
      h = m_hit(pc);
      if (jp) begin
         m_v[i] = 1; m_j[i] = 1; m_tag[i] = pc >> 6;
         m_tgt[i] = tgt; m_c[i] = 3;
      end else if (br && h) begin
         m_j[i] = 0;
         if (tk) begin
            m_tgt[i] = tgt;
            m_c[i] = (m_c[i] + 1 > 3) ? 3 : m_c[i] + 1;
         end else begin
            m_c[i] = (m_c[i] - 1 < 0) ? 0 : m_c[i] - 1;
         end
      end else if (br && tk) begin
         m_v[i] = 1; m_j[i] = 0; m_tag[i] = pc >> 6;
         m_tgt[i] = tgt; m_c[i] = 2;
      end else if (!br && h) begin
         m_v[i] = 0;
      end
      if (br || jp) m_br = m_br + 1;
      if (!ok) m_mis = m_mis + 1;
   endtask

   logic [31:0] pool [12];
   logic [31:0] e_br;
   logic [31:0] e_mis;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      idle(32'h60, 32'h64, 0);
      upd(1, 0, 1, 32'h100, 32'h80, 32'h104,
          32'h100, 32'h104, 0, 0, 32'h80);
      idle(32'h100, 32'h80, 1);
      upd(1, 0, 0, 32'h100, 32'h80, 32'h80,
          32'h100, 32'h80, 1, 0, 32'h104);
      idle(32'h100, 32'h104, 0);
      upd(1, 0, 0, 32'h100, 32'h80, 32'h104,
          32'h100, 32'h104, 0, 1, 32'h104);
      upd(1, 0, 1, 32'h100, 32'h80, 32'h104,
          32'h100, 32'h104, 0, 0, 32'h80);
      upd(1, 0, 1, 32'h100, 32'h80, 32'h104,
          32'h100, 32'h104, 0, 0, 32'h80);
      upd(1, 0, 1, 32'h100, 32'h80, 32'h80,
          32'h100, 32'h80, 1, 1, 32'h80);
      upd(1, 0, 1, 32'h100, 32'h80, 32'h80,
          32'h100, 32'h80, 1, 1, 32'h80);
      upd(1, 0, 0, 32'h100, 32'h80, 32'h80,
          32'h100, 32'h80, 1, 0, 32'h104);
      idle(32'h100, 32'h80, 1);
      upd(1, 0, 0, 32'h100, 32'h80, 32'h80,
          32'h100, 32'h80, 1, 0, 32'h104);
      idle(32'h100, 32'h104, 0);
      upd(0, 1, 0, 32'h200, 32'h400, 32'h204,
          32'h200, 32'h204, 0, 0, 32'h400);
      idle(32'h200, 32'h400, 1);
      upd(1, 0, 0, 32'h240, 32'h900, 32'h244,
          32'h200, 32'h400, 1, 1, 32'h244);
      idle(32'h200, 32'h400, 1);
      upd(0, 0, 0, 32'h200, 32'h0, 32'h400,
          32'h200, 32'h400, 1, 0, 32'h204);
      idle(32'h200, 32'h204, 0);
      idle(32'hFFFFFFFC, 32'h0, 0);
      upd(1, 1, 0, 32'h200, 32'h300, 32'h204,
          32'h240, 32'h244, 0, 0, 32'h300);
      idle(32'h200, 32'h300, 1);
      upd(1, 0, 1, 32'h240, 32'h500, 32'h244,
          32'h200, 32'h300, 1, 0, 32'h500);
      idle(32'h200, 32'h204, 0);
      idle(32'h240, 32'h500, 1);

      chk("reset_br_count", bus.br_count, 32'h0);
      chk("reset_mis_count", bus.mispredict_count, 32'h0);

      e_br  = 0;
      e_mis = 0;
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].uv, tbl[i].br, tbl[i].jp, tbl[i].tk,
               tbl[i].upc, tbl[i].utgt, tbl[i].upred, tbl[i].ipc);
         #1;
         chk($sformatf("v%0d_pred_pc", i), bus.pred_pc,
             tbl[i].e_pred);
         chk($sformatf("v%0d_pred_taken", i),
             32'(bus.pred_taken), 32'(tbl[i].e_ptk));
         chk($sformatf("v%0d_cpp", i),
             32'(bus.correct_pc_prediction), 32'(tbl[i].e_cpp));
         chk($sformatf("v%0d_correct_pc", i), bus.correct_pc,
             tbl[i].e_cpc);
         if (tbl[i].uv && (tbl[i].br || tbl[i].jp)) e_br++;
         if (tbl[i].uv && !tbl[i].e_cpp) e_mis++;
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("tbl_br_count", bus.br_count, e_br);
      chk("tbl_mis_count", bus.mispredict_count, e_mis);

      // Reset wins over a simultaneous update.
      @(negedge clk);
      rst = 1'b1;
      drive(1, 0, 1, 0, 32'h300, 32'h500, 32'h304, 32'h300);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 32'h300);
      #1;
      chk("rstupd_pred_pc", bus.pred_pc, 32'h304);
      chk("rstupd_taken", 32'(bus.pred_taken), 32'h0);
      chk("rstupd_br_count", bus.br_count, 32'h0);
      chk("rstupd_mis_count", bus.mispredict_count, 32'h0);
      bus.if_pc = 32'h240;
      #1;
      chk("rstupd_cleared", bus.pred_pc, 32'h244);

      // br_count wrap from all-ones.
      @(negedge clk);
      force dut.r_br_count = 32'hFFFFFFFF;
      #1;
      release dut.r_br_count;
      drive(1, 0, 1, 0, 32'h380, 32'h10, 32'h10, 32'h380);
      #1;
      chk("preload_br_count", bus.br_count, 32'hFFFFFFFF);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 32'h380);
      #1;
      chk("wrap_br_count", bus.br_count, 32'h0);
      chk("wrap_mis_count", bus.mispredict_count, 32'h0);
      chk("wrap_jump_pred", bus.pred_pc, 32'h10);

      pool = '{32'h100, 32'h140, 32'h200, 32'h1000, 32'h104,
               32'h144, 32'h108, 32'hFFFFFFFC, 32'h3C, 32'h7C,
               32'h2040, 32'h80};
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_clear();
      for (int n = 0; n < 400; n++) begin
         logic uv, br, jp, tk, m_tk, u_tk;
         logic [31:0] upc, tgt, upred, ipc, m_pc, u_pc, act;
         int kind;
         @(negedge clk);
         uv   = ($urandom_range(0, 4) != 0);
         kind = $urandom_range(0, 9);
         br   = (kind <= 5) || (kind == 9);
         jp   = (kind == 6) || (kind == 7) || (kind == 9);
         tk   = $urandom_range(0, 1) != 0;
         upc  = pool[$urandom_range(0, 11)];
         tgt  = pool[$urandom_range(0, 11)];
         ipc  = ($urandom_range(0, 3) == 0) ? upc
                                            : pool[$urandom_range(0, 11)];
         m_predict(upc, u_pc, u_tk);
         upred = ($urandom_range(0, 2) != 0) ? u_pc
                                             : pool[$urandom_range(0, 11)];
         drive(uv, br, jp, tk, upc, tgt, upred, ipc);
         #1;
         m_predict(ipc, m_pc, m_tk);
         act = jp ? tgt : (br && tk) ? tgt : upc + 32'd4;
         chk("rnd_pred_pc", bus.pred_pc, m_pc);
         chk("rnd_pred_taken", 32'(bus.pred_taken), 32'(m_tk));
         chk("rnd_correct_pc", bus.correct_pc, act);
         chk("rnd_cpp", 32'(bus.correct_pc_prediction),
             32'(!uv || (upred == act)));
         if (uv) m_train(br, jp, tk, upc, tgt, upred == act);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("rnd_br_count", bus.br_count, m_br);
      chk("rnd_mis_count", bus.mispredict_count, m_mis);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
